// File: rtl/airhockey_pkg.sv
// Shared types and widths for the air-hockey game-frame datapath.
package airhockey_pkg;

  localparam int FRAME_CNT_W = 16;
  localparam int OVR_CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INPUT = 3'd1,
    ST_PHYS  = 3'd2,
    ST_COLL  = 3'd3,
    ST_SCORE = 3'd4
  } state_e;

  // Saturating increment for the overrun counter.
  function automatic logic [OVR_CNT_W-1:0] sat_inc_ovr(input logic [OVR_CNT_W-1:0] v);
    if (v == {OVR_CNT_W{1'b1}}) begin
      sat_inc_ovr = v;
    end else begin
      sat_inc_ovr = v + {{(OVR_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/game_tick_scheduler_tick_divider.sv
// Decimates the tick400 pulse stream into one frame request every TICKS pulses.
module tick_divider #(
  parameter int TICKS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick400,
  output logic frame_req
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [CW-1:0] cnt_r;
  logic          wrap_s;

  // The request fires in the same cycle as the wrapping tick.
  always_comb begin
    wrap_s = tick400 && (cnt_r == CW'(TICKS - 1));
  end

  // Tick counter, free-running regardless of scheduler state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (wrap_s) begin
      cnt_r <= '0;
    end else if (tick400) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign frame_req = wrap_s;

endmodule

// File: rtl/game_tick_scheduler.sv
// Launches one game-frame update (input, physics, collision, score) per frame
// request, with overrun counting and a per-phase watchdog.
module game_tick_scheduler
  import airhockey_pkg::*;
#(
  parameter int TICKS_PER_FRAME = 8,
  parameter int TIMEOUT         = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick400,
  input  logic                   pause,
  input  logic                   in_done,
  input  logic                   phys_done,
  input  logic                   col_done,
  input  logic                   score_done,
  input  logic                   goal,
  output logic                   in_start,
  output logic                   phys_start,
  output logic                   col_start,
  output logic                   score_start,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [OVR_CNT_W-1:0]   overrun_count,
  output logic                   fault
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_e                 state_r, state_s;
  logic [WD_W-1:0]        wd_r, wd_s;
  logic [FRAME_CNT_W-1:0] frame_cnt_r, frame_cnt_s;
  logic [OVR_CNT_W-1:0]   ovr_r, ovr_s;
  logic                   fault_r, fault_s;
  logic                   busy_r, busy_s;
  logic                   in_start_r, phys_start_r, col_start_r, score_start_r;
  logic                   in_start_s, phys_start_s, col_start_s, score_start_s;
  logic                   frame_req_s;
  logic                   phase_done_s;
  logic                   first_s;

  tick_divider #(
    .TICKS (TICKS_PER_FRAME)
  ) u_tick_divider (
    .clk       (clk),
    .rst       (rst),
    .tick400   (tick400),
    .frame_req (frame_req_s)
  );

  // Select the done pulse that belongs to the current phase.
  always_comb begin
    phase_done_s = 1'b0;
    case (state_r)
      ST_INPUT: phase_done_s = in_done;
      ST_PHYS:  phase_done_s = phys_done;
      ST_COLL:  phase_done_s = col_done;
      ST_SCORE: phase_done_s = score_done;
      default:  phase_done_s = 1'b0;
    endcase
  end

  // Next-state, counters and registered-output next values.
  always_comb begin
    state_s     = state_r;
    wd_s        = wd_r;
    frame_cnt_s = frame_cnt_r;
    ovr_s       = ovr_r;
    fault_s     = fault_r;
    // A done arriving alongside its own start is too early to be genuine.
    first_s     = in_start_r | phys_start_r | col_start_r | score_start_r;

    if (state_r == ST_IDLE) begin
      if (frame_req_s && !pause) begin
        state_s = ST_INPUT;
      end else begin
        state_s = ST_IDLE;
      end
    end else begin
      if (frame_req_s) begin
        ovr_s = sat_inc_ovr(ovr_r);
      end else begin
        ovr_s = ovr_r;
      end

      if (phase_done_s && !first_s) begin
        case (state_r)
          ST_INPUT: state_s = ST_PHYS;
          ST_PHYS:  state_s = ST_COLL;
          ST_COLL: begin
            if (goal) begin
              state_s = ST_SCORE;
            end else begin
              state_s     = ST_IDLE;
              frame_cnt_s = frame_cnt_r + FRAME_CNT_W'(1);
            end
          end
          ST_SCORE: begin
            state_s     = ST_IDLE;
            frame_cnt_s = frame_cnt_r + FRAME_CNT_W'(1);
          end
          default: state_s = ST_IDLE;
        endcase
      end else if (wd_r == WD_W'(TIMEOUT - 1)) begin
        fault_s = 1'b1;
        state_s = ST_IDLE;
      end else begin
        wd_s = wd_r + WD_W'(1);
      end
    end

    if (state_s != state_r) begin
      wd_s = '0;
    end else begin
      wd_s = wd_s;
    end

    in_start_s    = (state_s == ST_INPUT) && (state_r != ST_INPUT);
    phys_start_s  = (state_s == ST_PHYS)  && (state_r != ST_PHYS);
    col_start_s   = (state_s == ST_COLL)  && (state_r != ST_COLL);
    score_start_s = (state_s == ST_SCORE) && (state_r != ST_SCORE);
    busy_s        = (state_s != ST_IDLE);
  end

  // State, counters and all outputs are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      wd_r          <= '0;
      frame_cnt_r   <= '0;
      ovr_r         <= '0;
      fault_r       <= 1'b0;
      busy_r        <= 1'b0;
      in_start_r    <= 1'b0;
      phys_start_r  <= 1'b0;
      col_start_r   <= 1'b0;
      score_start_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      wd_r          <= wd_s;
      frame_cnt_r   <= frame_cnt_s;
      ovr_r         <= ovr_s;
      fault_r       <= fault_s;
      busy_r        <= busy_s;
      in_start_r    <= in_start_s;
      phys_start_r  <= phys_start_s;
      col_start_r   <= col_start_s;
      score_start_r <= score_start_s;
    end
  end

  assign in_start      = in_start_r;
  assign phys_start    = phys_start_r;
  assign col_start     = col_start_r;
  assign score_start   = score_start_r;
  assign busy          = busy_r;
  assign frame_count   = frame_cnt_r;
  assign overrun_count = ovr_r;
  assign fault         = fault_r;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler: frame sequencing, goal path,
// watchdog abort, pause, overrun saturation and mid-frame reset.
module tb_game_tick_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick400 = 1'b0;
  logic        pause = 1'b0;
  logic        in_done = 1'b0, phys_done = 1'b0, col_done = 1'b0, score_done = 1'b0;
  logic        goal = 1'b0;
  logic        in_start, phys_start, col_start, score_start, busy, fault;
  logic [15:0] frame_count;
  logic [7:0]  overrun_count;

  logic        tick1 = 1'b0;
  logic        in_start1, phys_start1, col_start1, score_start1, busy1, fault1;
  logic [15:0] frame_count1;
  logic [7:0]  overrun_count1;

  logic en_in = 1'b1, en_phys = 1'b1, en_col = 1'b1, en_score = 1'b1, goal_val = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_in = 0, n_phys = 0, n_col = 0, n_score = 0;
  int in_cyc = 0, phys_cyc = 0, col_cyc = 0, score_cyc = 0;

  game_tick_scheduler #(.TICKS_PER_FRAME(8), .TIMEOUT(16)) u_dut (
    .clk(clk), .rst(rst), .tick400(tick400), .pause(pause),
    .in_done(in_done), .phys_done(phys_done), .col_done(col_done), .score_done(score_done),
    .goal(goal),
    .in_start(in_start), .phys_start(phys_start), .col_start(col_start), .score_start(score_start),
    .busy(busy), .frame_count(frame_count), .overrun_count(overrun_count), .fault(fault)
  );

  game_tick_scheduler #(.TICKS_PER_FRAME(1), .TIMEOUT(1023)) u_dut_ovr (
    .clk(clk), .rst(rst), .tick400(tick1), .pause(1'b0),
    .in_done(1'b0), .phys_done(1'b0), .col_done(1'b0), .score_done(1'b0),
    .goal(1'b0),
    .in_start(in_start1), .phys_start(phys_start1), .col_start(col_start1), .score_start(score_start1),
    .busy(busy1), .frame_count(frame_count1), .overrun_count(overrun_count1), .fault(fault1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (in_start)    begin n_in++;    in_cyc    = cyc; end
    if (phys_start)  begin n_phys++;  phys_cyc  = cyc; end
    if (col_start)   begin n_col++;   col_cyc   = cyc; end
    if (score_start) begin n_score++; score_cyc = cyc; end
  end

  // Phase-block model: each done returns two cycles after its start.
  initial begin
    int d_in = 0, d_phys = 0, d_col = 0, d_score = 0;
    forever begin
      @(posedge clk); #1;
      in_done    = en_in    && (d_in == 1);
      phys_done  = en_phys  && (d_phys == 1);
      col_done   = en_col   && (d_col == 1);
      score_done = en_score && (d_score == 1);
      goal       = col_done && goal_val;
      if (d_in > 0)    d_in--;
      if (d_phys > 0)  d_phys--;
      if (d_col > 0)   d_col--;
      if (d_score > 0) d_score--;
      if (in_start)    d_in = 2;
      if (phys_start)  d_phys = 2;
      if (col_start)   d_col = 2;
      if (score_start) d_score = 2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 tick400 = 1'b1;
      @(posedge clk); #1 tick400 = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    @(negedge clk);
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
    $fatal(1, "bench timeout");
  end

  initial begin
    int b_in, b_phys, b_col, b_score, n, idle_cyc;

    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_overrun", 32'(overrun_count), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_starts", 32'({in_start, phys_start, col_start, score_start}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Plain frame, no goal.
    b_in = n_in; b_phys = n_phys; b_col = n_col; b_score = n_score;
    send_ticks(8);
    @(negedge clk);
    chk("launch_in_start", 32'(in_start), 32'd1);
    chk("launch_busy", 32'(busy), 32'd1);
    wait_idle(60);
    chk("f1_frame_count", 32'(frame_count), 32'd1);
    chk("f1_in_cnt", 32'(n_in - b_in), 32'd1);
    chk("f1_phys_cnt", 32'(n_phys - b_phys), 32'd1);
    chk("f1_col_cnt", 32'(n_col - b_col), 32'd1);
    chk("f1_score_cnt", 32'(n_score - b_score), 32'd0);
    chk("f1_in_to_phys", 32'(phys_cyc - in_cyc), 32'd3);
    chk("f1_phys_to_col", 32'(col_cyc - phys_cyc), 32'd3);
    chk("f1_overrun", 32'(overrun_count), 32'd0);

    // Goal frame.
    goal_val = 1'b1;
    b_score = n_score;
    send_ticks(8);
    n = 0;
    @(negedge clk);
    while (!score_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("f2_score_start", 32'(score_start), 32'd1);
    chk("f2_fc_before_done", 32'(frame_count), 32'd1);
    chk("f2_busy", 32'(busy), 32'd1);
    wait_idle(60);
    goal_val = 1'b0;
    chk("f2_frame_count", 32'(frame_count), 32'd2);
    chk("f2_score_cnt", 32'(n_score - b_score), 32'd1);
    chk("f2_col_to_score", 32'(score_cyc - col_cyc), 32'd3);

    // Watchdog abort with phys_done withheld.
    en_phys = 1'b0;
    b_col = n_col;
    send_ticks(8);
    wait_idle(60);
    idle_cyc = cyc;
    chk("wd_abort_latency", 32'(idle_cyc - phys_cyc), 32'd16);
    chk("wd_fault", 32'(fault), 32'd1);
    chk("wd_frame_count", 32'(frame_count), 32'd2);
    chk("wd_no_col", 32'(n_col - b_col), 32'd0);
    en_phys = 1'b1;
    send_ticks(8);
    wait_idle(60);
    chk("wd_next_frame_count", 32'(frame_count), 32'd3);
    chk("wd_fault_sticky", 32'(fault), 32'd1);

    // Pause drops frame requests without counting overruns.
    pause = 1'b1;
    b_in = n_in;
    send_ticks(24);
    @(negedge clk);
    chk("pause_no_start", 32'(n_in - b_in), 32'd0);
    chk("pause_overrun", 32'(overrun_count), 32'd0);
    chk("pause_busy", 32'(busy), 32'd0);
    pause = 1'b0;
    send_ticks(8);
    @(negedge clk);
    chk("unpause_in_start", 32'(in_start), 32'd1);
    wait_idle(60);
    chk("unpause_frame_count", 32'(frame_count), 32'd4);

    // Overrun saturation on the single-tick-per-frame instance.
    @(posedge clk); #1 tick1 = 1'b1;
    repeat (100) @(posedge clk);
    #1 tick1 = 1'b0;
    @(negedge clk);
    chk("ovr_99", 32'(overrun_count1), 32'd99);
    @(posedge clk); #1 tick1 = 1'b1;
    repeat (200) @(posedge clk);
    #1 tick1 = 1'b0;
    @(negedge clk);
    chk("ovr_saturate", 32'(overrun_count1), 32'd255);
    chk("ovr_busy", 32'(busy1), 32'd1);
    chk("ovr_fault", 32'(fault1), 32'd0);

    // Reset asserted while in COLL.
    goal_val = 1'b1;
    send_ticks(8);
    n = 0;
    @(negedge clk);
    while (!col_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rstm_in_coll", 32'(col_start), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_frame_count", 32'(frame_count), 32'd0);
    chk("rstm_fault", 32'(fault), 32'd0);
    chk("rstm_starts", 32'({in_start, phys_start, col_start, score_start}), 32'd0);
    chk("rstm_ovr1", 32'(overrun_count1), 32'd0);
    b_col = n_col; b_score = n_score; b_in = n_in;
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rstm_no_col", 32'(n_col - b_col), 32'd0);
    chk("rstm_no_score", 32'(n_score - b_score), 32'd0);
    chk("rstm_no_in", 32'(n_in - b_in), 32'd0);
    chk("rstm_idle", 32'(busy), 32'd0);
    goal_val = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
